// File: rtl/seq_loop_pkg.sv
// rtl/seq_loop_pkg.sv - state encodings and shared types for the single-loop sequencer
package seq_loop_pkg;

    // Default state vector width; the top level carries its own FSM_WIDTH parameter.
    localparam int SEQ_FSM_WIDTH = 4;

    typedef logic [SEQ_FSM_WIDTH-1:0] state_t;

    // Fixed codes that do not depend on the body length.
    localparam int ST_IDLE = 0;
    localparam int ST_PRE  = 1;

    // Code of body state k (BODY0 is the first state of every iteration).
    function automatic int st_body(input int k);
        return 2 + k;
    endfunction

    // Code of the last body state for a body of body_states states.
    function automatic int st_body_last(input int body_states);
        return st_body(body_states - 1);
    endfunction

    // Code of the post-loop state, directly after the last body state.
    function automatic int st_post(input int body_states);
        return body_states + 2;
    endfunction

endpackage

// File: rtl/seq_loop_iter_cnt.sv
// rtl/seq_loop_iter_cnt.sv - trip count latch and iteration index with last-iteration compare
module seq_loop_iter_cnt
    import seq_loop_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic [CNT_WIDTH-1:0] trip_i,
    input  logic                 clear_i,
    input  logic                 inc_i,
    output logic [CNT_WIDTH-1:0] iter_idx_o,
    output logic                 trip_zero_o,
    output logic                 is_last_o
);

    logic [CNT_WIDTH-1:0] trip_q, trip_d;
    logic [CNT_WIDTH-1:0] iter_idx_q, iter_idx_d;

    // Load the trip count on start; clear the index before the first iteration, bump it between iterations.
    always_comb begin
        trip_d     = trip_q;
        iter_idx_d = iter_idx_q;
        if (load_i) begin
            trip_d = trip_i;
        end
        if (clear_i) begin
            iter_idx_d = '0;
        end else if (inc_i) begin
            iter_idx_d = iter_idx_q + CNT_WIDTH'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            trip_q     <= '0;
            iter_idx_q <= '0;
        end else begin
            trip_q     <= trip_d;
            iter_idx_q <= iter_idx_d;
        end
    end

    assign iter_idx_o  = iter_idx_q;
    assign trip_zero_o = (trip_q == '0);
    // trip_q-1 only matters when trip_q is non-zero, so the wrap at zero is masked off.
    assign is_last_o   = (trip_q != '0) && (iter_idx_q == trip_q - CNT_WIDTH'(1));

endmodule

// File: rtl/seq_loop_ctrl.sv
// rtl/seq_loop_ctrl.sv - ap_start/ap_done sequencer for one loop: pre state, body iterations, post state
module seq_loop_ctrl
    import seq_loop_pkg::*;
#(
    parameter int FSM_WIDTH   = 4,
    parameter int BODY_STATES = 3,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ap_start,
    input  logic [CNT_WIDTH-1:0] trip_count,
    input  logic                 body_stall,
    output logic                 ap_idle,
    output logic                 ap_ready,
    output logic                 ap_done,
    output logic [FSM_WIDTH-1:0] cur_state,
    output logic [CNT_WIDTH-1:0] iter_idx,
    output logic                 iter_start,
    output logic                 iter_end,
    output logic                 loop_quit,
    output logic                 one_state_loop
);

    localparam logic [FSM_WIDTH-1:0] S_IDLE      = FSM_WIDTH'(ST_IDLE);
    localparam logic [FSM_WIDTH-1:0] S_PRE       = FSM_WIDTH'(ST_PRE);
    localparam logic [FSM_WIDTH-1:0] S_BODY0     = FSM_WIDTH'(st_body(0));
    localparam logic [FSM_WIDTH-1:0] S_BODY_LAST = FSM_WIDTH'(st_body_last(BODY_STATES));
    localparam logic [FSM_WIDTH-1:0] S_POST      = FSM_WIDTH'(st_post(BODY_STATES));

    logic [FSM_WIDTH-1:0] state_q, state_d;
    logic                 in_body;
    logic                 advance;
    logic                 cnt_load, cnt_clear, cnt_inc;
    logic                 trip_zero, is_last;

    // Body states are contiguous codes, so a range test identifies them for any body length.
    assign in_body = (state_q >= S_BODY0) && (state_q <= S_BODY_LAST);
    assign advance = in_body && !body_stall;

    // Next-state and counter control; POST and any unused code fall back to IDLE.
    always_comb begin
        state_d   = state_q;
        cnt_load  = 1'b0;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        if (state_q == S_IDLE) begin
            if (ap_start) begin
                cnt_load = 1'b1;
                state_d  = S_PRE;
            end
        end else if (state_q == S_PRE) begin
            cnt_clear = 1'b1;
            state_d   = trip_zero ? S_POST : S_BODY0;
        end else if (in_body) begin
            if (!body_stall) begin
                if (state_q == S_BODY_LAST) begin
                    if (is_last) begin
                        state_d = S_POST;
                    end else begin
                        cnt_inc = 1'b1;
                        state_d = S_BODY0;
                    end
                end else begin
                    state_d = state_q + FSM_WIDTH'(1);
                end
            end
        end else begin
            state_d = S_IDLE;
        end
    end

    // State register; reset aborts any call in flight without a done pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    seq_loop_iter_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_iter_cnt (
        .clk_i       (clock),
        .rst_i       (reset),
        .load_i      (cnt_load),
        .trip_i      (trip_count),
        .clear_i     (cnt_clear),
        .inc_i       (cnt_inc),
        .iter_idx_o  (iter_idx),
        .trip_zero_o (trip_zero),
        .is_last_o   (is_last)
    );

    assign cur_state      = state_q;
    assign ap_idle        = (state_q == S_IDLE);
    assign ap_done        = (state_q == S_POST);
    assign ap_ready       = (state_q == S_POST);
    assign iter_start     = advance && (state_q == S_BODY0);
    assign iter_end       = advance && (state_q == S_BODY_LAST);
    // Exit is decided either in PRE for an empty loop or when the final iteration completes.
    assign loop_quit      = ((state_q == S_PRE) && trip_zero) || (iter_end && is_last);
    assign one_state_loop = (BODY_STATES == 1);

endmodule

// File: tb/tb_seq_loop_ctrl.sv
// tb/tb_seq_loop_ctrl.sv - randomized self-checking bench for seq_loop_ctrl against a trace model
module tb_seq_loop_ctrl;
    import seq_loop_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ap_start;
    logic        stall;
    logic [15:0] trip;
    bit          sel;

    logic        start3, start1;
    logic        idle3, ready3, done3, istart3, iend3, quit3, one3;
    logic        idle1, ready1, done1, istart1, iend1, quit1, one1;
    logic [3:0]  st3, st1;
    logic [15:0] idx3, idx1;

    logic [3:0]  o_st;
    logic [15:0] o_idx;
    logic [5:0]  o_fl;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        int       st;
        int       idx;
        bit       stall;
        bit [5:0] fl;
    } ent_t;

    ent_t tr[$];
    int   stall_n[16][4];
    int   prev_idx[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign start3 = ap_start & ~sel;
    assign start1 = ap_start & sel;

    seq_loop_ctrl #(.FSM_WIDTH(4), .BODY_STATES(3), .CNT_WIDTH(16)) u_dut3 (
        .clock(clk), .reset(rst), .ap_start(start3), .trip_count(trip), .body_stall(stall),
        .ap_idle(idle3), .ap_ready(ready3), .ap_done(done3), .cur_state(st3), .iter_idx(idx3),
        .iter_start(istart3), .iter_end(iend3), .loop_quit(quit3), .one_state_loop(one3)
    );

    seq_loop_ctrl #(.FSM_WIDTH(4), .BODY_STATES(1), .CNT_WIDTH(16)) u_dut1 (
        .clock(clk), .reset(rst), .ap_start(start1), .trip_count(trip), .body_stall(stall),
        .ap_idle(idle1), .ap_ready(ready1), .ap_done(done1), .cur_state(st1), .iter_idx(idx1),
        .iter_start(istart1), .iter_end(iend1), .loop_quit(quit1), .one_state_loop(one1)
    );

    // Observed outputs of the DUT under test; flags are {istart, iend, quit, done, ready, idle}.
    always_comb begin
        if (sel) begin
            o_st  = st1;
            o_idx = idx1;
            o_fl  = {istart1, iend1, quit1, done1, ready1, idle1};
        end else begin
            o_st  = st3;
            o_idx = idx3;
            o_fl  = {istart3, iend3, quit3, done3, ready3, idle3};
        end
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_stalls();
        for (int i = 0; i < 16; i++)
            for (int k = 0; k < 4; k++)
                stall_n[i][k] = 0;
    endtask

    task automatic rand_stalls(input int t, input int b, output int sum);
        sum = 0;
        clear_stalls();
        for (int i = 0; i < t; i++)
            for (int k = 0; k < b; k++)
                if ($urandom_range(0, 2) == 0) begin
                    stall_n[i][k] = $urandom_range(1, 2);
                    sum += stall_n[i][k];
                end
    endtask

    // Expected cycle-by-cycle trace of one call from PRE through POST.
    task automatic build_trace(input int b, input int t);
        ent_t e;
        tr.delete();
        e.st = 1; e.idx = prev_idx[sel]; e.stall = 1'($urandom_range(0, 1));
        e.fl = {1'b0, 1'b0, (t == 0), 3'b000};
        tr.push_back(e);
        for (int i = 0; i < t; i++) begin
            for (int k = 0; k < b; k++) begin
                for (int s = 0; s < stall_n[i][k]; s++) begin
                    e.st = 2 + k; e.idx = i; e.stall = 1'b1; e.fl = 6'b0;
                    tr.push_back(e);
                end
                e.st = 2 + k; e.idx = i; e.stall = 1'b0;
                e.fl = {(k == 0), (k == b - 1), (k == b - 1 && i == t - 1), 3'b000};
                tr.push_back(e);
            end
        end
        e.st = b + 2; e.idx = (t == 0) ? 0 : t - 1; e.stall = 1'($urandom_range(0, 1));
        e.fl = 6'b000110;
        tr.push_back(e);
    endtask

    task automatic check_cycle(input string tag, input int st, input int idx, input bit [5:0] fl);
        check_val({tag, "_state"}, int'(o_st), st);
        check_val({tag, "_idx"}, int'(o_idx), idx);
        check_val({tag, "_flags"}, int'(o_fl), int'(fl));
    endtask

    task automatic idle_cycle();
        ap_start = 1'b0;
        stall = 1'($urandom_range(0, 1));
        @(negedge clk);
        check_cycle("idle", 0, prev_idx[sel], 6'b000001);
        @(posedge clk); #1;
    endtask

    task automatic run_call(input int t, input bit hold, input int abort_at,
                            output int lat, output int ns, output int ne, output int nq,
                            output int done_cyc);
        int b;
        b = sel ? 1 : 3;
        build_trace(b, t);
        lat = -1; ns = 0; ne = 0; nq = 0; done_cyc = -1;
        ap_start = 1'b1;
        trip = 16'(t);
        stall = 1'($urandom_range(0, 1));
        @(negedge clk);
        check_cycle("accept", 0, prev_idx[sel], 6'b000001);
        @(posedge clk); #1;
        foreach (tr[c]) begin
            ap_start = hold ? 1'b1 : 1'($urandom_range(0, 1));
            trip = 16'($urandom);
            stall = tr[c].stall;
            @(negedge clk);
            check_cycle($sformatf("call_t%0d_c%0d", t, c), tr[c].st, tr[c].idx, tr[c].fl);
            if (o_fl[5]) ns++;
            if (o_fl[4]) ne++;
            if (o_fl[3]) nq++;
            if (o_fl[2] && lat < 0) begin
                lat = c + 1;
                done_cyc = cyc;
            end
            if (c == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                ap_start = 1'b0;
                @(negedge clk);
                check_cycle("abort", 0, 0, 6'b000001);
                prev_idx[0] = 0;
                prev_idx[1] = 0;
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        prev_idx[sel] = (t == 0) ? 0 : t - 1;
    endtask

    initial begin
        int lat, ns, ne, nq, dc, d0, d1, d2, d3, sum, t, b;
        bit hold;
        rst = 1'b1; ap_start = 1'b0; stall = 1'b0; trip = '0; sel = 1'b0;
        prev_idx[0] = 0; prev_idx[1] = 0;
        clear_stalls();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_cycle("reset3", 0, 0, 6'b000001);
        sel = 1'b1;
        #1;
        check_cycle("reset1", 0, 0, 6'b000001);
        sel = 1'b0;
        check_val("one_state3", int'(one3), 0);
        check_val("one_state1", int'(one1), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_cycle();

        // Trip 4, three body states, no stall.
        run_call(4, 1'b0, -1, lat, ns, ne, nq, dc);
        check_val("t4_latency", lat, 14);
        check_val("t4_istart", ns, 4);
        check_val("t4_iend", ne, 4);
        check_val("t4_quit", nq, 1);
        idle_cycle();

        // Empty loop.
        run_call(0, 1'b0, -1, lat, ns, ne, nq, dc);
        check_val("t0_latency", lat, 2);
        check_val("t0_istart", ns, 0);
        check_val("t0_quit", nq, 1);
        idle_cycle();

        // One-state loop.
        sel = 1'b1;
        idle_cycle();
        run_call(5, 1'b0, -1, lat, ns, ne, nq, dc);
        check_val("b1_latency", lat, 7);
        check_val("b1_istart", ns, 5);
        check_val("b1_iend", ne, 5);
        idle_cycle();
        sel = 1'b0;
        idle_cycle();

        // Three stall cycles in BODY1 of iteration 2.
        clear_stalls();
        stall_n[2][1] = 3;
        run_call(4, 1'b0, -1, lat, ns, ne, nq, dc);
        check_val("stall_latency", lat, 17);
        check_val("stall_istart", ns, 4);
        clear_stalls();
        idle_cycle();

        // Reset in BODY2 of iteration 1 (trace index 1 + 1*3 + 2), then a normal call.
        run_call(4, 1'b0, 6, lat, ns, ne, nq, dc);
        check_val("abort_no_done", lat, -1);
        run_call(2, 1'b0, -1, lat, ns, ne, nq, dc);
        check_val("after_abort_latency", lat, 8);
        idle_cycle();

        // ap_start held high: back-to-back calls.
        run_call(1, 1'b1, -1, lat, ns, ne, nq, d0);
        run_call(1, 1'b1, -1, lat, ns, ne, nq, d1);
        run_call(1, 1'b1, -1, lat, ns, ne, nq, d2);
        run_call(2, 1'b1, -1, lat, ns, ne, nq, d3);
        check_val("hold_period_a", d1 - d0, 6);
        check_val("hold_period_b", d2 - d1, 6);
        check_val("hold_period_c", d3 - d2, 9);
        idle_cycle();

        // Randomized calls with random stalls on both body lengths.
        repeat (30) begin
            sel = 1'($urandom_range(0, 1));
            b = sel ? 1 : 3;
            t = $urandom_range(0, 7);
            hold = 1'($urandom_range(0, 1));
            rand_stalls(t, b, sum);
            run_call(t, hold, -1, lat, ns, ne, nq, dc);
            check_val("rnd_latency", lat, 2 + t * b + sum);
            check_val("rnd_istart", ns, t);
            check_val("rnd_iend", ne, t);
            check_val("rnd_quit", nq, 1);
            if (!hold) idle_cycle();
        end
        clear_stalls();
        idle_cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
